// File: rtl/regfile_bwm.sv
// regfile_bwm: 2-read / 1-write general-purpose register file.
// Features: per-byte write mask, registered reads with same-cycle write
// bypass, an optional hard-wired zero register, and a sequential clear
// engine that zeroes every entry after reset or when clr is requested.
module regfile_bwm #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                clr,
    output logic                ready,
    input  logic                reg_write,
    input  logic [ADDR_W-1:0]   w_addr,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [DATA_W/8-1:0] w_mask,
    input  logic [ADDR_W-1:0]   r_addr1,
    input  logic [ADDR_W-1:0]   r_addr2,
    output logic [DATA_W-1:0]   r_data1,
    output logic [DATA_W-1:0]   r_data2
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   ptr_reg, ptr_next;

    logic                wr_en;
    logic                zero_hit1, zero_hit2;
    logic [DATA_W-1:0]   rd1_merged, rd2_merged;
    logic [DATA_W-1:0]   rd1_next, rd2_next;

    assign ready = (state_reg == ST_READY);

    // A write only lands when the array is usable; address 0 is read-only
    // when it is hard-wired to zero. Dropping it here also kills its bypass.
    assign wr_en = ready && reg_write &&
                   !((ZERO_REG != 0) && (w_addr == '0));

    assign zero_hit1 = (ZERO_REG != 0) && (r_addr1 == '0);
    assign zero_hit2 = (ZERO_REG != 0) && (r_addr2 == '0);

    // Clear-engine state and sweep pointer; reset restarts the sweep at 0.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_reg <= ST_CLEAR;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Next-state: sweep one entry per cycle, return to READY after the last.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            ST_CLEAR: begin
                ptr_next = ptr_reg + 1'b1;
                if (ptr_reg == {ADDR_W{1'b1}}) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (clr) begin
                    state_next = ST_CLEAR;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = ST_CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    // One byte-wide storage lane per mask bit, so each byte has its own
    // write enable. The lanes carry no reset; the sweep initialises them.
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_rd1, lane_rd2;
        logic       lane_we;

        assign lane_we  = wr_en && w_mask[gi];
        assign lane_rd1 = lane_mem[r_addr1];
        assign lane_rd2 = lane_mem[r_addr2];

        // Sweep writes zero at the pointer; otherwise a masked-in byte write.
        always_ff @(posedge clk) begin
            if (!ready) begin
                lane_mem[ptr_reg] <= 8'h00;
            end else if (lane_we) begin
                lane_mem[w_addr] <= w_data[8*gi +: 8];
            end
        end

        // Bypass per byte: a read of the address being written sees the
        // incoming byte only where the mask enables it.
        assign rd1_merged[8*gi +: 8] = (lane_we && (w_addr == r_addr1)) ?
                                       w_data[8*gi +: 8] : lane_rd1;
        assign rd2_merged[8*gi +: 8] = (lane_we && (w_addr == r_addr2)) ?
                                       w_data[8*gi +: 8] : lane_rd2;
    end

    assign rd1_next = zero_hit1 ? '0 : rd1_merged;
    assign rd2_next = zero_hit2 ? '0 : rd2_merged;

    // Registered read ports; forced to zero under reset and during a sweep.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_data1 <= '0;
            r_data2 <= '0;
        end else if (!ready) begin
            r_data1 <= '0;
            r_data2 <= '0;
        end else begin
            r_data1 <= rd1_next;
            r_data2 <= rd2_next;
        end
    end

endmodule

// File: tb/tb_regfile_bwm.sv
// Self-checking bench for regfile_bwm: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_regfile_bwm;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              srst;
    logic              clr;
    logic              ready;
    logic              reg_write;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [7:0]        w_mask;
    logic [ADDR_W-1:0] r_addr1, r_addr2;
    logic [DATA_W-1:0] r_data1, r_data2;

    int checks = 0;
    int errors = 0;

    regfile_bwm #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
        .clk      (clk),
        .srst     (srst),
        .clr      (clr),
        .ready    (ready),
        .reg_write(reg_write),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .w_mask   (w_mask),
        .r_addr1  (r_addr1),
        .r_addr2  (r_addr2),
        .r_data1  (r_data1),
        .r_data2  (r_data2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: word array, a countdown of remaining sweep cycles,
    // and the expected registered outputs. Reads return the post-write word.
    logic [63:0] mem_model [DEPTH];
    int          clear_left;
    logic        exp_ready;
    logic [63:0] exp_r1, exp_r2;

    always @(posedge clk or posedge srst) begin
        if (srst) begin
            clear_left = DEPTH;
            exp_ready  = 1'b0;
            exp_r1     = '0;
            exp_r2     = '0;
            for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
        end else if (clear_left > 0) begin
            clear_left = clear_left - 1;
            exp_r1     = '0;
            exp_r2     = '0;
            exp_ready  = (clear_left == 0);
        end else begin
            if (reg_write && w_addr != 0) begin
                for (int k = 0; k < 8; k++)
                    if (w_mask[k]) mem_model[w_addr][8*k +: 8] = w_data[8*k +: 8];
            end
            exp_r1 = (r_addr1 == 0) ? 64'd0 : mem_model[r_addr1];
            exp_r2 = (r_addr2 == 0) ? 64'd0 : mem_model[r_addr2];
            if (clr) begin
                for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
                clear_left = DEPTH;
                exp_ready  = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (srst === 1'b0) begin
            check("model_ready", {63'd0, ready}, {63'd0, exp_ready});
            check("model_r1", r_data1, exp_r1);
            check("model_r2", r_data2, exp_r2);
        end
    end

    task automatic idle();
        reg_write = 1'b0;
        clr       = 1'b0;
        w_mask    = 8'h00;
        w_addr    = '0;
        w_data    = '0;
    endtask

    task automatic do_write(input int a, input logic [63:0] d, input logic [7:0] m);
        reg_write = 1'b1;
        w_addr    = ADDR_W'(a);
        w_data    = d;
        w_mask    = m;
        @(negedge clk);
        idle();
    endtask

    task automatic do_read(input int a1, input int a2, input logic [63:0] e1,
                           input logic [63:0] e2, input string name);
        r_addr1 = ADDR_W'(a1);
        r_addr2 = ADDR_W'(a2);
        @(negedge clk);
        check({name, "_p1"}, r_data1, e1);
        check({name, "_p2"}, r_data2, e2);
        $display("read a1=%0d a2=%0d -> %h %h", a1, a2, r_data1, r_data2);
    endtask

    // Waits (bounded) for ready and returns the number of low cycles seen.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    int          n;
    logic [63:0] e2;

    initial begin
        srst = 1'b1;
        idle();
        r_addr1 = '0;
        r_addr2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        srst = 1'b0;
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_r1", r_data1, 64'd0);
        wait_ready(n);
        check("rst_sweep_len", 64'(n), 64'd32);
        $display("reset sweep: ready after %0d cycles", n);

        for (int i = 0; i < DEPTH; i++) do_read(i, DEPTH - 1 - i, 64'd0, 64'd0, "init_zero");

        // Full-mask writes and cross reads.
        for (int i = 1; i <= 7; i++) do_write(i, 64'(i + 15), 8'hFF);
        for (int i = 1; i <= 7; i++) begin
            e2 = (i == 7) ? 64'd0 : 64'(7 - i + 15);
            do_read(i, 7 - i, 64'(i + 15), e2, "full_mask");
        end
        do_write(0, 64'hFF, 8'hFF);
        do_read(0, 0, 64'd0, 64'd0, "zero_reg");

        // Byte mask behaviour.
        do_write(5, 64'h1122334455667788, 8'hFF);
        do_write(5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        do_read(5, 5, 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA, "byte_mask");
        do_write(5, 64'h0, 8'h00);
        do_read(5, 5, 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA, "mask_zero");

        // Same-cycle write bypass on both ports, then a neighbouring entry.
        reg_write = 1'b1; w_addr = 5; w_data = 64'd25; w_mask = 8'hFF;
        r_addr1 = 5; r_addr2 = 5;
        @(negedge clk);
        idle();
        check("bypass_p1", r_data1, 64'd25);
        check("bypass_p2", r_data2, 64'd25);
        $display("bypass write 5 -> %h %h", r_data1, r_data2);
        do_read(4, 4, 64'd19, 64'd19, "after_bypass");

        // Randomized traffic, including occasional clear requests.
        for (int c = 0; c < 400; c++) begin
            reg_write = 1'($urandom_range(0, 1));
            w_addr    = ADDR_W'($urandom);
            w_data    = {$urandom, $urandom};
            w_mask    = 8'($urandom);
            r_addr1   = ADDR_W'($urandom);
            r_addr2   = ($urandom_range(0, 3) == 0) ? w_addr : ADDR_W'($urandom);
            clr       = ($urandom_range(0, 59) == 0);
            @(negedge clk);
            $display("rand %0d we=%0b wa=%0d m=%h ra=%0d/%0d rd=%h/%h", c, reg_write,
                     w_addr, w_mask, r_addr1, r_addr2, r_data1, r_data2);
        end
        idle();
        wait_ready(n);
        check("rand_ready_bound", {63'd0, ready}, 64'd1);

        // Clear request with a simultaneous write; writes during the sweep lost.
        for (int i = 1; i < DEPTH; i++) do_write(i, 64'hA5A5_0000 + 64'(i), 8'hFF);
        clr = 1'b1; reg_write = 1'b1; w_addr = 3; w_data = 64'h1234; w_mask = 8'hFF;
        @(negedge clk);
        clr = 1'b0;
        check("clr_ready_drop", {63'd0, ready}, 64'd0);
        w_data = 64'hDEAD;
        wait_ready(n);
        idle();
        check("clr_sweep_len", 64'(n), 64'd32);
        $display("clear sweep: ready after %0d cycles", n);
        for (int i = 0; i < DEPTH; i++) do_read(i, i, 64'd0, 64'd0, "clr_zero");

        // Asynchronous reset between edges while a write is in progress.
        do_write(7, 64'h0BAD_F00D, 8'hFF);
        do_read(7, 7, 64'h0BAD_F00D, 64'h0BAD_F00D, "pre_async");
        reg_write = 1'b1; w_addr = 9; w_data = 64'h77; w_mask = 8'hFF;
        #2;
        srst = 1'b1;
        #1;
        check("async_ready", {63'd0, ready}, 64'd0);
        check("async_r1", r_data1, 64'd0);
        check("async_r2", r_data2, 64'd0);
        $display("async reset: ready=%0b r=%h/%h", ready, r_data1, r_data2);
        @(posedge clk);
        @(negedge clk);
        idle();
        srst = 1'b0;
        wait_ready(n);
        check("async_sweep_len", 64'(n), 64'd32);
        do_read(7, 9, 64'd0, 64'd0, "post_async");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
